// File: rtl/ov5640_sccb_axil_regs_pkg.sv
// Shared constants and types for the OV5640 SCCB AXI-Lite register block.
// Optional build macro: OV5640_SCCB_IRQ_EN (adds CTRL irq_enable bit).
package ov5640_sccb_pkg;

  localparam int unsigned AXI_DATA_W  = 32;
  localparam int unsigned AXI_ADDR_W  = 4;
  localparam int unsigned SCCB_ADDR_W = 16;
  localparam int unsigned SCCB_DATA_W = 8;

  // Register word index (byte offset >> 2)
  localparam logic [1:0] REG_ADDR  = 2'd0;
  localparam logic [1:0] REG_WDATA = 2'd1;
  localparam logic [1:0] REG_CTRL  = 2'd2;
  localparam logic [1:0] REG_RDATA = 2'd3;

  // CTRL write bit positions
  localparam int unsigned CTRL_LAUNCH_BIT = 0;
  localparam int unsigned CTRL_RW_BIT     = 1;
  localparam int unsigned CTRL_DONE_BIT   = 2;
`ifdef OV5640_SCCB_IRQ_EN
  localparam int unsigned CTRL_IRQEN_BIT  = 3;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/ov5640_sccb_axil_regs_if.sv
// AXI4-Lite channel bundle between the interconnect (master) and the register block (slave).
interface ov5640_sccb_axil_regs_if #(
  parameter int unsigned DATA_W = ov5640_sccb_pkg::AXI_DATA_W,
  parameter int unsigned ADDR_W = ov5640_sccb_pkg::AXI_ADDR_W
) ();

  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );

endinterface

// File: rtl/ov5640_sccb_axil_regs_sccb_cmd_fsm.sv
// Single-outstanding command sequencer toward the SCCB engine: snapshots the
// launch parameters, runs the valid/ready request and captures the response.
module sccb_cmd_fsm
  import ov5640_sccb_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   launch,
  input  logic                   launch_rw,
  input  logic [SCCB_ADDR_W-1:0] launch_addr,
  input  logic [SCCB_DATA_W-1:0] launch_wdata,
  input  logic                   done_clr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_rw,
  output logic [SCCB_ADDR_W-1:0] cmd_addr,
  output logic [SCCB_DATA_W-1:0] cmd_wdata,
  input  logic                   rsp_valid,
  input  logic [SCCB_DATA_W-1:0] rsp_rdata,
  input  logic                   rsp_err,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   rw_last,
  output logic [SCCB_DATA_W-1:0] rdata
);

  cmd_state_t             state_q, state_d;
  logic                   cmd_valid_q, cmd_valid_d;
  logic                   cmd_rw_q, cmd_rw_d;
  logic [SCCB_ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [SCCB_DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic                   rw_last_q, rw_last_d;
  logic [SCCB_DATA_W-1:0] rdata_q, rdata_d;
  logic                   complete_c;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_rw_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rw_last_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rw_last_q   <= rw_last_d;
      rdata_q     <= rdata_d;
    end
  end

  // Next-state: responses outside WAIT are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch)                   state_d = REQ;
      REQ:     if (cmd_valid_q && cmd_ready) state_d = WAIT;
      WAIT:    if (rsp_valid)                state_d = IDLE;
      default:                               state_d = IDLE;
    endcase
  end

  // Outputs: snapshot on launch, status capture on completion (set beats W1C)
  always_comb begin
    cmd_rw_d    = cmd_rw_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    done_d      = done_q;
    err_d       = err_q;
    rw_last_d   = rw_last_q;
    rdata_d     = rdata_q;
    complete_c  = (state_q == WAIT) && rsp_valid;
    cmd_valid_d = (state_d == REQ);
    busy_d      = (state_d != IDLE);
    if ((state_q == IDLE) && launch) begin
      cmd_rw_d    = launch_rw;
      cmd_addr_d  = launch_addr;
      cmd_wdata_d = launch_wdata;
    end
    if (done_clr) done_d = 1'b0;
    if (complete_c) begin
      done_d    = 1'b1;
      err_d     = rsp_err;
      rw_last_d = cmd_rw_q;
      if (cmd_rw_q && !rsp_err) rdata_d = rsp_rdata;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_rw    = cmd_rw_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rw_last   = rw_last_q;
  assign rdata     = rdata_q;

endmodule

// File: rtl/ov5640_sccb_axil_regs.sv
// AXI4-Lite register block for OV5640 sensor configuration over SCCB.
// Optional build macro: OV5640_SCCB_IRQ_EN (irq output + CTRL irq_enable bit).
module ov5640_sccb_axil_regs
  import ov5640_sccb_pkg::*;
#(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                   s00_axi_aclk,
  input  logic                   s00_axi_aresetn,
  ov5640_sccb_axil_regs_if.slave s00_axi,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic                   cmd_rw,
  output logic [SCCB_ADDR_W-1:0] cmd_addr,
  output logic [SCCB_DATA_W-1:0] cmd_wdata,
  input  logic                   rsp_valid,
  input  logic [SCCB_DATA_W-1:0] rsp_rdata,
  input  logic                   rsp_err
`ifdef OV5640_SCCB_IRQ_EN
  ,
  output logic                   irq
`endif
);

  localparam int unsigned STRB_W = C_S_AXI_DATA_WIDTH / 8;

  logic                          aw_lat_q, aw_lat_d;
  logic [1:0]                    aw_idx_q, aw_idx_d;
  logic                          w_lat_q, w_lat_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          awready_q, awready_d;
  logic                          wready_q, wready_d;
  logic                          bvalid_q, bvalid_d;
  logic [1:0]                    bresp_q, bresp_d;
  logic                          arready_q, arready_d;
  logic                          rvalid_q, rvalid_d;
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [SCCB_ADDR_W-1:0]        addr_q, addr_d;
  logic [SCCB_DATA_W-1:0]        wreg_q, wreg_d;
`ifdef OV5640_SCCB_IRQ_EN
  logic                          irq_en_q, irq_en_d;
  logic                          irq_q, irq_d;
`endif

  logic                          launch_c, launch_rw_c, done_clr_c;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_mux_c;
  logic                          busy, done, err, rw_last;
  logic [SCCB_DATA_W-1:0]        rdata_reg;
  logic                          unused_c;

  assign unused_c = ^{s00_axi.awprot, s00_axi.arprot,
                      wdata_q[C_S_AXI_DATA_WIDTH-1:16], wstrb_q[STRB_W-1:2]};

  sccb_cmd_fsm u_cmd_fsm (
    .clk          (s00_axi_aclk),
    .rst_n        (s00_axi_aresetn),
    .launch       (launch_c),
    .launch_rw    (launch_rw_c),
    .launch_addr  (addr_q),
    .launch_wdata (wreg_q),
    .done_clr     (done_clr_c),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rw       (cmd_rw),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .rw_last      (rw_last),
    .rdata        (rdata_reg)
  );

  // AXI channel and register-file state
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_lat_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_lat_q   <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wreg_q    <= '0;
`ifdef OV5640_SCCB_IRQ_EN
      irq_en_q  <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      aw_lat_q  <= aw_lat_d;
      aw_idx_q  <= aw_idx_d;
      w_lat_q   <= w_lat_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wreg_q    <= wreg_d;
`ifdef OV5640_SCCB_IRQ_EN
      irq_en_q  <= irq_en_d;
      irq_q     <= irq_d;
`endif
    end
  end

  // Write path: independent AW/W latches, commit the cycle after both are held
  always_comb begin
    aw_lat_d    = aw_lat_q;
    aw_idx_d    = aw_idx_q;
    w_lat_d     = w_lat_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    addr_d      = addr_q;
    wreg_d      = wreg_q;
    launch_c    = 1'b0;
    launch_rw_c = 1'b0;
    done_clr_c  = 1'b0;
`ifdef OV5640_SCCB_IRQ_EN
    irq_en_d    = irq_en_q;
`endif
    if (s00_axi.awvalid && awready_q) begin
      aw_lat_d = 1'b1;
      aw_idx_d = s00_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (s00_axi.wvalid && wready_q) begin
      w_lat_d = 1'b1;
      wdata_d = s00_axi.wdata;
      wstrb_d = s00_axi.wstrb;
    end
    if (bvalid_q && s00_axi.bready) bvalid_d = 1'b0;
    if (aw_lat_q && w_lat_q) begin
      aw_lat_d = 1'b0;
      w_lat_d  = 1'b0;
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (aw_idx_q)
        REG_ADDR: begin
          if (wstrb_q[0]) addr_d[7:0]  = wdata_q[7:0];
          if (wstrb_q[1]) addr_d[15:8] = wdata_q[15:8];
        end
        REG_WDATA: begin
          if (wstrb_q[0]) wreg_d = wdata_q[7:0];
        end
        REG_CTRL: begin
          if (wstrb_q[0]) begin
            done_clr_c = wdata_q[CTRL_DONE_BIT];
`ifdef OV5640_SCCB_IRQ_EN
            irq_en_d   = wdata_q[CTRL_IRQEN_BIT];
`endif
            // busy is the pre-update value, so a launch racing rsp_valid is rejected
            if (wdata_q[CTRL_LAUNCH_BIT]) begin
              if (busy) begin
                bresp_d = RESP_SLVERR;
              end else begin
                launch_c    = 1'b1;
                launch_rw_c = wdata_q[CTRL_RW_BIT];
              end
            end
          end
        end
        default: bresp_d = RESP_SLVERR;
      endcase
    end
    awready_d = !aw_lat_d && !bvalid_d;
    wready_d  = !w_lat_d && !bvalid_d;
  end

  // Read data mux over current register contents
  always_comb begin
    rd_mux_c = '0;
    case (s00_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2])
      REG_ADDR:  rd_mux_c[15:0] = addr_q;
      REG_WDATA: rd_mux_c[7:0]  = wreg_q;
`ifdef OV5640_SCCB_IRQ_EN
      REG_CTRL:  rd_mux_c[4:0]  = {busy, irq_en_q, done, err, rw_last};
`else
      REG_CTRL:  rd_mux_c[3:0]  = {busy, done, err, rw_last};
`endif
      default:   rd_mux_c[7:0]  = rdata_reg;
    endcase
  end

  // Read path: one outstanding read, data registered on AR handshake
  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s00_axi.rready) rvalid_d = 1'b0;
    if (s00_axi.arvalid && arready_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux_c;
    end
    arready_d = !rvalid_d;
  end

`ifdef OV5640_SCCB_IRQ_EN
  // Level interrupt tracks done while enabled
  always_comb begin
    irq_d = done && irq_en_q;
  end
  assign irq = irq_q;
`endif

  assign s00_axi.awready = awready_q;
  assign s00_axi.wready  = wready_q;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.arready = arready_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = RESP_OKAY;

endmodule

// File: tb/tb_ov5640_sccb_axil_regs.sv
// Directed bench for the OV5640 SCCB AXI-Lite register block.
`timescale 1ns/1ps
module tb_ov5640_sccb_axil_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_rw;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_rdata;

  int vectors = 0;
  int miscompares = 0;

  int          cyc = 0;
  int          hs_cnt = 0;
  int          cv_cnt = 0;
  int          cv_rise = -1;
  int          bv_rise = -2;
  logic        cv_prev = 1'b0;
  logic        bv_prev = 1'b0;
  logic [15:0] cap_addr = '0;
  logic [7:0]  cap_wdata = '0;
  logic        cap_rw = 1'b0;

  always #5 clk = ~clk;

  ov5640_sccb_axil_regs_if axi ();

  ov5640_sccb_axil_regs dut (
    .s00_axi_aclk    (clk),
    .s00_axi_aresetn (rst_n),
    .s00_axi         (axi),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_rw          (cmd_rw),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .rsp_valid       (rsp_valid),
    .rsp_rdata       (rsp_rdata),
    .rsp_err         (rsp_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Command-port and B-channel observer
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready) begin
      hs_cnt    <= hs_cnt + 1;
      cap_addr  <= cmd_addr;
      cap_wdata <= cmd_wdata;
      cap_rw    <= cmd_rw;
    end
    if (cmd_valid) cv_cnt <= cv_cnt + 1;
    if (cmd_valid && !cv_prev) cv_rise <= cyc;
    if (axi.bvalid && !bv_prev) bv_rise <= cyc;
    cv_prev <= cmd_valid;
    bv_prev <= axi.bvalid;
  end

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                           input logic [3:0] s, output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    bit got = 0;
    int n = 0;
    resp = 2'bxx;
    @(posedge clk); #1;
    axi.awaddr = a; axi.awvalid = 1'b1;
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      bit awh, wh;
      @(negedge clk);
      awh = axi.awready && !aw_done;
      wh  = axi.wready && !w_done;
      @(posedge clk); #1;
      if (awh) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (wh)  begin axi.wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    axi.bready = 1'b1;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (axi.bvalid) begin resp = axi.bresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    axi.bready = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    if (!(aw_done && w_done && got)) begin
      vectors++; miscompares++;
      $display("FAIL axi_write_timeout addr=%h: aw=%0b w=%0b b=%0b, required all 1", a, aw_done, w_done, got);
    end
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ar_done = 0;
    bit got = 0;
    int n = 0;
    d = 'x; resp = 2'bxx;
    @(posedge clk); #1;
    axi.araddr = a; axi.arvalid = 1'b1;
    while (!ar_done && n < 50) begin
      bit arh;
      @(negedge clk);
      arh = axi.arready;
      @(posedge clk); #1;
      if (arh) begin axi.arvalid = 1'b0; ar_done = 1; end
      n++;
    end
    axi.rready = 1'b1;
    n = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      if (axi.rvalid) begin d = axi.rdata; resp = axi.rresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    axi.rready = 1'b0; axi.arvalid = 1'b0;
    if (!(ar_done && got)) begin
      vectors++; miscompares++;
      $display("FAIL axi_read_timeout addr=%h: ar=%0b r=%0b, required both 1", a, ar_done, got);
    end
  endtask

  task automatic pulse_rsp(input logic [7:0] d, input logic e);
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_rdata = d; rsp_err = e;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_rdata = 8'h00; rsp_err = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic [1:0] r;
    logic [5:0] outs;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {cmd_valid, axi.bvalid, axi.rvalid, axi.awready, axi.wready, axi.arready};
    vectors++;
    if (outs !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required 000000", outs);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_stat: got %h required 00000000", d); end
    axi_read(4'h0, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_addr: got %h required 00000000", d); end
  endtask

  task automatic test_regs();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'h0, 32'h0000_3008, 4'hF, r);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL bresp_addr: got %b required 00", r); end
    axi_write(4'h4, 32'hFFFF_FF82, 4'hF, r);
    axi_read(4'h0, d, r);
    vectors++;
    if (d !== 32'h0000_3008 || r !== 2'b00) begin
      miscompares++; $display("FAIL read_addr: got %h/%b required 00003008/00", d, r);
    end
    axi_read(4'h4, d, r);
    vectors++;
    if (d !== 32'h0000_0082 || r !== 2'b00) begin
      miscompares++; $display("FAIL read_wdata: got %h/%b required 00000082/00", d, r);
    end
    // byte strobes: low byte only, then no byte at all
    axi_write(4'h0, 32'hFFFF_AB55, 4'b0001, r);
    axi_read(4'h0, d, r);
    vectors++;
    if (d !== 32'h0000_3055) begin miscompares++; $display("FAIL wstrb_addr: got %h required 00003055", d); end
    axi_write(4'h4, 32'h0000_0011, 4'b0000, r);
    axi_read(4'h4, d, r);
    vectors++;
    if (d !== 32'h0000_0082) begin miscompares++; $display("FAIL wstrb_none: got %h required 00000082", d); end
    axi_write(4'h0, 32'h0000_3008, 4'hF, r);
  endtask

  task automatic test_launch_write();
    logic [31:0] d; logic [1:0] r;
    int hs0, cv0;
    cmd_ready = 1'b1;
    hs0 = hs_cnt; cv0 = cv_cnt;
    axi_write(4'h8, 32'h1, 4'hF, r);
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (hs_cnt !== hs0 + 1 || cv_cnt !== cv0 + 1) begin
      miscompares++; $display("FAIL launch_pulse: hs=%0d cv=%0d required %0d/%0d", hs_cnt - hs0, cv_cnt - cv0, 1, 1);
    end
    vectors++;
    if (cap_addr !== 16'h3008 || cap_wdata !== 8'h82 || cap_rw !== 1'b0) begin
      miscompares++; $display("FAIL launch_fields: got %h/%h/%b required 3008/82/0", cap_addr, cap_wdata, cap_rw);
    end
    vectors++;
    if (cv_rise !== bv_rise) begin
      miscompares++; $display("FAIL launch_latency: cmd_valid cycle %0d bvalid cycle %0d, required equal", cv_rise, bv_rise);
    end
    pulse_rsp(8'hAA, 1'b0);
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL stat_done_write: got %h required 00000004", d); end
    axi_write(4'h8, 32'h4, 4'hF, r);
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL stat_w1c: got %h required 00000000", d); end
  endtask

  task automatic test_launch_read();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'h8, 32'h3, 4'hF, r);
    pulse_rsp(8'h56, 1'b0);
    axi_read(4'hC, d, r);
    vectors++;
    if (d !== 32'h56) begin miscompares++; $display("FAIL rdata_read: got %h required 00000056", d); end
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h5) begin miscompares++; $display("FAIL stat_read: got %h required 00000005", d); end
    axi_write(4'h8, 32'h3, 4'hF, r);
    pulse_rsp(8'h99, 1'b1);
    axi_read(4'hC, d, r);
    vectors++;
    if (d !== 32'h56) begin miscompares++; $display("FAIL rdata_err_kept: got %h required 00000056", d); end
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h7) begin miscompares++; $display("FAIL stat_err: got %h required 00000007", d); end
  endtask

  task automatic test_busy();
    logic [31:0] d; logic [1:0] r;
    int hs0;
    cmd_ready = 1'b0;
    hs0 = hs_cnt;
    axi_write(4'h8, 32'h5, 4'hF, r);
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'hB) begin miscompares++; $display("FAIL stat_busy: got %h required 0000000b", d); end
    axi_write(4'h0, 32'h1234, 4'hF, r);
    vectors++;
    if (r !== 2'b00) begin miscompares++; $display("FAIL bresp_addr_busy: got %b required 00", r); end
    axi_write(4'h8, 32'h3, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin miscompares++; $display("FAIL bresp_launch_busy: got %b required 10", r); end
    repeat (10) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (cmd_valid !== 1'b1 || cmd_addr !== 16'h3008 || cmd_wdata !== 8'h82 || cmd_rw !== 1'b0) begin
      miscompares++;
      $display("FAIL snapshot_hold: got %b/%h/%h/%b required 1/3008/82/0", cmd_valid, cmd_addr, cmd_wdata, cmd_rw);
    end
    @(posedge clk); #1 cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    pulse_rsp(8'h77, 1'b0);
    @(negedge clk);
    vectors++;
    if (hs_cnt !== hs0 + 1 || cap_addr !== 16'h3008) begin
      miscompares++; $display("FAIL busy_single_cmd: hs=%0d addr=%h required 1/3008", hs_cnt - hs0, cap_addr);
    end
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h4) begin miscompares++; $display("FAIL stat_after_busy: got %h required 00000004", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic [1:0] r;
    bit ok_hold = 1;
    bit aw_done = 0;
    bit w_done = 0;
    bit got = 0;
    int n = 0;
    @(posedge clk); #1;
    axi.wdata = 32'h5A; axi.wstrb = 4'hF; axi.wvalid = 1'b1; axi.awaddr = 4'h4;
    @(posedge clk); #1 axi.wvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 axi.awvalid = 1'b1;
    @(negedge clk);
    vectors++;
    if (axi.awready !== 1'b1 || axi.wready !== 1'b0) begin
      miscompares++; $display("FAIL w_first_latched: awready=%b wready=%b required 1/0", axi.awready, axi.wready);
    end
    @(posedge clk); #1 axi.awvalid = 1'b0;
    @(negedge clk);
    vectors++;
    if (axi.bvalid !== 1'b0) begin miscompares++; $display("FAIL b_latency_early: got %b required 0", axi.bvalid); end
    @(negedge clk);
    vectors++;
    if (axi.bvalid !== 1'b1) begin miscompares++; $display("FAIL b_latency: got %b required 1", axi.bvalid); end
    @(posedge clk); #1;
    axi.awaddr = 4'h0; axi.awvalid = 1'b1; axi.wdata = 32'hC3; axi.wvalid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (!axi.bvalid || axi.awready || axi.wready) ok_hold = 0;
    end
    vectors++;
    if (!ok_hold || axi.bresp !== 2'b00) begin
      miscompares++; $display("FAIL b_hold: hold=%0b bresp=%b required 1/00", ok_hold, axi.bresp);
    end
    @(posedge clk); #1 axi.bready = 1'b1;
    @(posedge clk); #1 axi.bready = 1'b0;
    while (!(aw_done && w_done) && n < 20) begin
      bit awh, wh;
      @(negedge clk);
      awh = axi.awready && !aw_done;
      wh  = axi.wready && !w_done;
      @(posedge clk); #1;
      if (awh) begin axi.awvalid = 1'b0; aw_done = 1; end
      if (wh)  begin axi.wvalid  = 1'b0; w_done  = 1; end
      n++;
    end
    axi.bready = 1'b1; n = 0;
    while (!got && n < 20) begin
      @(negedge clk);
      if (axi.bvalid) begin r = axi.bresp; got = 1; end
      @(posedge clk); #1;
      n++;
    end
    axi.bready = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    vectors++;
    if (!(aw_done && w_done && got) || r !== 2'b00) begin
      miscompares++; $display("FAIL second_write: aw=%0b w=%0b b=%0b resp=%b required 1/1/1/00", aw_done, w_done, got, r);
    end
    axi_read(4'h4, d, r);
    vectors++;
    if (d !== 32'h5A) begin miscompares++; $display("FAIL b2b_wdata: got %h required 0000005a", d); end
    axi_read(4'h0, d, r);
    vectors++;
    if (d !== 32'hC3) begin miscompares++; $display("FAIL b2b_addr: got %h required 000000c3", d); end
  endtask

  task automatic test_rdata_ro();
    logic [31:0] d; logic [1:0] r;
    axi_write(4'hC, 32'hFF, 4'hF, r);
    vectors++;
    if (r !== 2'b10) begin miscompares++; $display("FAIL bresp_rdata_wr: got %b required 10", r); end
    axi_read(4'hC, d, r);
    vectors++;
    if (d !== 32'h56 || r !== 2'b00) begin
      miscompares++; $display("FAIL rdata_ro: got %h/%b required 00000056/00", d, r);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic [1:0] r;
    int hs0;
    cmd_ready = 1'b0;
    axi_write(4'h8, 32'h1, 4'hF, r);
    @(negedge clk);
    vectors++;
    if (cmd_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_req: got %b required 1", cmd_valid); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (cmd_valid !== 1'b0) begin miscompares++; $display("FAIL reset_async_cmd: got %b required 0", cmd_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    hs0 = hs_cnt;
    cmd_ready = 1'b1;
    pulse_rsp(8'h33, 1'b0);
    axi_read(4'h8, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mid_stat: got %h required 00000000", d); end
    axi_read(4'h0, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mid_addr: got %h required 00000000", d); end
    axi_read(4'hC, d, r);
    vectors++;
    if (d !== 32'h0) begin miscompares++; $display("FAIL reset_mid_rdata: got %h required 00000000", d); end
    vectors++;
    if (hs_cnt !== hs0 || cmd_valid !== 1'b0) begin
      miscompares++; $display("FAIL reset_mid_no_cmd: hs=%0d valid=%b required 0/0", hs_cnt - hs0, cmd_valid);
    end
  endtask

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 8'h00; rsp_err = 1'b0;
    test_reset();
    test_regs();
    test_launch_write();
    test_launch_read();
    test_busy();
    test_back_to_back();
    test_rdata_ro();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ov5640_sccb_axil_regs.md
Name: ov5640_sccb_axil_regs

Overview:
- AXI4-Lite slave register block for OV5640 sensor configuration.
- The PS / AXI VIP master writes sensor register address, data and launch commands. The block issues one command at a time on a valid/ready port to the SCCB engine, captures its response, and exposes status and readback over AXI.
- Sits between the AXI interconnect (upstream) and the SCCB master (downstream).

Parameters:
- C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, AXI byte address width; 4 registers at 0x0/0x4/0x8/0xC.

Ports:
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  reset, asynchronous assert, active-low.
- s00_axi_awaddr/awprot/awvalid/awready  in/in/in/out  4/3/1/1  write address channel; awprot ignored.
- s00_axi_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
- s00_axi_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
- s00_axi_araddr/arprot/arvalid/arready  in/in/in/out  4/3/1/1  read address channel.
- s00_axi_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
- cmd_valid  out  1  command to SCCB engine.
- cmd_ready  in  1  engine accepts command.
- cmd_rw  out  1  0 = sensor write, 1 = sensor read.
- cmd_addr  out  16  sensor register address.
- cmd_wdata  out  8  sensor write data.
- rsp_valid  in  1  one-cycle completion pulse from engine.
- rsp_rdata  in  8  sensor read data.
- rsp_err  in  1  NACK / error flag.

Behaviour:
- Register map (byte offset, awaddr[3:2]):
  - 0x0 ADDR RW [15:0], upper bits read 0.
  - 0x4 WDATA RW [7:0], upper bits read 0.
  - 0x8 CTRL/STAT:
    - write: bit0 = launch; bit1 = rw, sampled with launch; bit2 = W1C done.
    - read: {28'b0, busy, done, err, rw_last}; rw_last = bit0, err = bit1, done = bit2, busy = bit3.
  - 0xC RDATA RO [7:0].
- Reset values: all registers, AXI ready/valid/resp outputs, and cmd_valid are 0; cmd_* data outputs are 0.
- Write channel:
  - AW and W are accepted independently, in either order or in the same cycle.
  - awready=1 while no AW is latched and bvalid=0; wready likewise for W.
  - The cycle after both are latched, the register is updated and bvalid rises; both latches clear.
  - bvalid holds until bready; no new AW/W is accepted while bvalid=1.
- WSTRB applies per byte to ADDR and WDATA. CTRL actions require wstrb[0].
- BRESP:
  - SLVERR (2'b10) for a write to 0xC (no effect), and for a launch while busy (launch ignored; the W1C in the same write still applies).
  - OKAY otherwise.
- Read channel:
  - arready=1 while rvalid=0.
  - On AR handshake, rdata is registered and rvalid=1 next cycle; holds until rready.
  - RRESP is always OKAY.
- Command FSM, states IDLE, REQ, WAIT:
  - IDLE -> REQ on an accepted launch. cmd_rw/cmd_addr/cmd_wdata are snapshotted from CTRL bit1/ADDR/WDATA and held stable. busy=1, cmd_valid=1.
  - REQ -> WAIT on cmd_valid & cmd_ready; cmd_valid drops the next cycle.
  - WAIT -> IDLE on rsp_valid:
    - busy=0, done=1, err=rsp_err, rw_last=cmd_rw.
    - RDATA=rsp_rdata only if cmd_rw=1 and rsp_err=0.
- Boundaries:
  - rsp_valid in IDLE or REQ: ignored.
  - done set and W1C in the same cycle: set wins.
  - Launch write in the same cycle as rsp_valid: busy is evaluated before update, so the launch is rejected with SLVERR.
  - ADDR/WDATA writes while busy: allowed; they do not alter the snapshot.
  - Reset mid-transaction: FSM goes to IDLE, cmd_valid drops immediately, pending AXI latches and responses are discarded.
- Latency:
  - AXI write: response 2 cycles after the last of AW/W.
  - AXI read: data 1 cycle after AR.
  - Launch: cmd_valid 1 cycle after the register-update cycle.

Optional Feature:
- Macro: OV5640_SCCB_IRQ_EN.
- With it: output irq (1 bit) and CTRL bit3 = irq_enable (RW, reset 0). irq = done & irq_enable, level-sensitive, registered; cleared via done W1C.
- Without it: no irq port; CTRL bit3 write is ignored and bit3 reads back busy as above.

Decomposition:
- Shared package ov5640_sccb_pkg: register offset localparams, CTRL bit indices, resp constants (OKAY=2'b00, SLVERR=2'b10), FSM enum typedef cmd_state_t.
- One natural sub-module, sccb_cmd_fsm: IDLE/REQ/WAIT, snapshot and response capture. The top holds the AXI channels and register file.

Test Plan:
- Write 0x0=0x3008, 0x4=0x82 -> read back 0x00003008, 0x00000082, BRESP/RRESP OKAY.
- Write 0x8=0x1 with cmd_ready tied 1 -> cmd_valid one cycle, cmd_addr=0x3008, cmd_wdata=0x82, cmd_rw=0. rsp_valid pulse, err=0 -> STAT reads 0x4; write 0x8=0x4 -> STAT 0x0.
- Launch a read (0x8=0x3), engine returns rsp_rdata=0x56 -> 0xC reads 0x56, STAT reads 0x5. A second read with rsp_err=1 -> 0xC still 0x56, STAT 0x7.
- Hold cmd_ready=0 for 10 cycles and launch again while busy -> second write BRESP=SLVERR, cmd_valid stays high, snapshot unchanged, STAT busy=1.
- Present W 3 cycles before AW, then AW/W together with bready held low for 5 cycles -> both writes land, bvalid held, no extra acceptance. Write to 0xC -> SLVERR, RDATA unchanged.
- Assert s00_axi_aresetn low while in WAIT -> cmd_valid=0 and all registers read 0 after release. A late rsp_valid after release is ignored.
